data_bus_mem_responder: RTL and testbench
=========================================

# data_bus_mem_responder

Word-addressed SRAM responder for the Ibex-style data bus (req/gnt/rvalid handshake). It is the target end of the core's data port: it grants requests, performs byte-enabled writes or reads into a local array, and returns in-order responses after a fixed latency. It flags out-of-window accesses with `err`. It sits inside the peripherals block as the data-RAM slave, alongside the GPIO/SPI/UART/timer decoders.

## Interface
Parameters:
- `BaseAddr`, 32'h0001_0000, byte address of word 0; aligned to 4*`Depth`.
- `Depth`, 1024, number of 32-bit words; power of two, ≥ 2.
- `Latency`, 1, cycles from grant to `rvalid`; legal range 1..4.
- `GntDelay`, 0, 0 = grant in the request cycle, 1 = grant one cycle after `req` is first seen.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset. Asynchronous, active-high.
- `req`  in  1  request valid
- `gnt`  out  1  request accepted this cycle
- `we`  in  1  1 = write, 0 = read
- `be`  in  4  byte enables (write only)
- `addr`  in  32  byte address; bits [1:0] ignored
- `wdata`  in  32  write data
- `wdata_intg`  in  7  ignored
- `rvalid`  out  1  response valid
- `rdata`  out  32  read data
- `rdata_intg`  out  7  constant 7'b0
- `err`  out  1  response error, qualified by `rvalid`

## Operation
- **Hit test:** `hit = (addr - BaseAddr) < 4*Depth`, computed in 32-bit unsigned arithmetic. The word index is `(addr - BaseAddr)[$clog2(Depth)+1:2]`.
- **Grant FSM**, used only when `GntDelay=1`. Two states:
  - IDLE: `gnt=0`. If `req`, go to WAIT.
  - WAIT: `gnt=req`. Return to IDLE whether or not `req` is still high; a dropped `req` is a protocol violation and is discarded.
  - Result: back-to-back requests are accepted every other cycle.
- **No FSM** when `GntDelay=0`: `gnt = req`, combinational.
- **Accepted write, hit:** on the grant edge, each byte lane i with `be[i]=1` is written from `wdata[8i+7:8i]`. The response has `rdata=0` and `err=0`.
- **Accepted read, hit:** the array is read at the grant edge. `rdata` carries the word as it was after any write committed on earlier edges. `err=0`.
- **Miss (either direction):** no array access. The response has `rdata=0` and `err=1`.
- **Response path:** every accepted request enters a `Latency`-stage delay line of {valid, rdata, err}.
  - The line advances every cycle; there is no backpressure.
  - Responses are strictly in order, one per accepted request.
- **Outstanding requests:** up to `Latency` may be outstanding. The requester enforces its own limit.
- **Array contents:** not reset.

## Timing
- **Reset values:** `gnt=0`, `rvalid=0`, `rdata=0`, `err=0`, `rdata_intg=0`, FSM in IDLE, delay line cleared.
- **Reset mid-operation:** all in-flight responses are dropped; no `rvalid` follows for them.
- **Writes during reset:** array writes are suppressed while `rst=1`. `gnt` is forced to 0 while `rst=1`.
- **Response latency:** a grant at edge N produces `rvalid=1` during cycle N+`Latency` (`Latency=1` → next cycle).
- **Non-response cycles:** `rdata` and `err` are 0 when `rvalid=0`.
- **Throughput:** one request per cycle when `GntDelay=0`, one per two cycles when `GntDelay=1`.
- **Read-after-write to the same word, back-to-back grants:** the read returns the new data.
- **Address wrap-around:** an `addr` below `BaseAddr` wraps to a large offset and is treated as a miss.

## Structure
- **Package `data_bus_mem_responder_pkg`** holds:
  - the typedef `resp_t` {valid, rdata[31:0], err};
  - the grant FSM state enum {IDLE, WAIT};
  - the constant `INTG_ZERO = 7'b0`.
- **Sub-module `resp_delay_line`:** parameterised by `Latency`, with ports `clk`, `rst`, `in` (`resp_t`) and `out` (`resp_t`). It implements the shift stages.
- **Top module:** the array, hit logic, and grant FSM stay in the top module.

## Test plan
All scenarios use default parameters unless stated.
1. **Basic write/read:** write 0xDEADBEEF to 0x0001_0010 with `be=4'hF`, then read 0x0001_0010 → `gnt` in the request cycle, `rvalid` one cycle later, `rdata=0xDEADBEEF`, `err=0`.
2. **Byte enables:** word preloaded with 0x11223344; write 0xAABBCCDD with `be=4'b0101`; read back → `0x11BB33DD`.
3. **Miss:** read 0x0001_1000 and write 0x0000_FFFC → both granted and both responses `err=1`, `rdata=0`; the array is unchanged (spot-check word 1023).
4. **Latency and back-to-back:** `Latency=3`. Four consecutive reads of words 0..3 → `rvalid` on cycles N+3..N+6 in order with the correct data. Also issue a write then an immediate read of the same word → the read returns the new data.
5. **Grant delay:** `GntDelay=1`, `req` held high for 6 cycles → `gnt` pattern 0,1,0,1,0,1. With `req` dropped in WAIT → no grant and no response.
6. **Reset mid-flight:** `Latency=2`, assert `rst` one cycle after a read grant → `rvalid` never asserts for that read; all outputs 0 during reset; the next access after release completes normally.

Source files
------------

// File: rtl/data_bus_mem_responder_pkg.sv
// ----------------------------------------------------------------------------
// data_bus_mem_responder_pkg
//   Shared types and constants for the data-bus SRAM responder.
//   - resp_t       : one response slot {valid, rdata, err} carried down the
//                    fixed-latency response pipeline.
//   - gnt_state_e  : grant FSM states, used only when the grant is delayed.
//   - INTG_ZERO    : value driven on the unused read-integrity output.
// ----------------------------------------------------------------------------
package data_bus_mem_responder_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } gnt_state_e;

    localparam logic [6:0] INTG_ZERO = 7'b0;

endpackage

// File: rtl/resp_delay_line.sv
// ----------------------------------------------------------------------------
// resp_delay_line
//   Fixed-latency shift pipeline for responses. Every cycle the input slot is
//   shifted in and the oldest slot appears on the output; there is no
//   backpressure. Reset empties every stage, dropping in-flight responses.
//
// Ports:
//   clk  in   clock
//   rst  in   asynchronous active-high reset
//   in   in   resp_t entering stage 0
//   out  out  resp_t leaving stage Latency-1
// ----------------------------------------------------------------------------
module resp_delay_line
    import data_bus_mem_responder_pkg::*;
#(
    parameter int unsigned Latency = 1
) (
    input  logic  clk,
    input  logic  rst,
    input  resp_t in,
    output resp_t out
);

    resp_t stage_q [Latency];
    resp_t stage_d [Latency];

    // NOTE: every variable an always_comb writes gets a value on every path
    // (here, unconditionally); a path that skips one would infer a latch.
    always_comb begin
        stage_d[0] = in;
        for (int i = 1; i < Latency; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // NOTE: sequential state is updated with <= so every stage samples the
    // previous value of its neighbour; = here would collapse the pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < Latency; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign out = stage_q[Latency-1];

endmodule

// File: rtl/data_bus_mem_responder.sv
// ----------------------------------------------------------------------------
// data_bus_mem_responder
//   Word-addressed SRAM target for a req/gnt/rvalid data bus. Grants requests
//   (immediately, or every other cycle when GntDelay=1), performs byte-enabled
//   writes and reads on a local array, and returns in-order responses after
//   Latency cycles. Accesses outside [BaseAddr, BaseAddr+4*Depth) respond with
//   err=1 and rdata=0 and leave the array untouched.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   req / gnt       request valid / request accepted this cycle
//   we, be          write enable, byte enables (writes only)
//   addr            byte address, bits [1:0] ignored
//   wdata           write data; wdata_intg ignored
//   rvalid          response valid
//   rdata, err      response data / error, both 0 when rvalid=0
//   rdata_intg      constant zero
// ----------------------------------------------------------------------------
module data_bus_mem_responder
    import data_bus_mem_responder_pkg::*;
#(
    parameter logic [31:0] BaseAddr = 32'h0001_0000,
    parameter int unsigned Depth    = 1024,
    parameter int unsigned Latency  = 1,
    parameter int unsigned GntDelay = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    output logic        gnt,
    input  logic        we,
    input  logic [3:0]  be,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [6:0]  wdata_intg,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic [6:0]  rdata_intg,
    output logic        err
);

    localparam int unsigned IdxW        = $clog2(Depth);
    localparam logic [31:0] WindowBytes = 32'(4 * Depth);

    // ------------------------------------------------------------------
    // Hit test: an address below BaseAddr wraps to a huge offset and so
    // falls outside the window without a separate lower-bound compare.
    // ------------------------------------------------------------------
    logic [31:0]     offset;
    logic            hit;
    logic [IdxW-1:0] word_idx;

    assign offset   = addr - BaseAddr;
    assign hit      = offset < WindowBytes;
    assign word_idx = offset[IdxW+1:2];

    // ------------------------------------------------------------------
    // Grant generation. Reset masks the grant so nothing is accepted or
    // written while rst is high.
    // ------------------------------------------------------------------
    logic gnt_int;

    if (GntDelay == 0) begin : g_gnt_comb
        assign gnt_int = req & ~rst;
    end else begin : g_gnt_fsm
        gnt_state_e state_q;
        gnt_state_e state_d;
        logic       grant_fsm;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= IDLE;
            end else begin
                state_q <= state_d;
            end
        end

        // WAIT always returns to IDLE: a request dropped while waiting is
        // simply discarded, giving one grant per two cycles at most.
        always_comb begin
            state_d   = state_q;
            grant_fsm = 1'b0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    grant_fsm = req;
                    state_d   = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        assign gnt_int = grant_fsm & ~rst;
    end

    assign gnt = gnt_int;

    // ------------------------------------------------------------------
    // Storage array.
    // ------------------------------------------------------------------
    logic [31:0] mem_q [Depth];

    // NOTE: the array has no reset; clearing Depth words would defeat RAM
    // inference and the contents are undefined after power-up anyway.
    always_ff @(posedge clk) begin
        if (gnt_int && we && hit) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[word_idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Response formation. The read samples the array in the grant cycle,
    // so it sees every write committed on earlier edges (back-to-back
    // read-after-write returns the new word).
    // ------------------------------------------------------------------
    resp_t resp_in;
    resp_t resp_out;

    always_comb begin
        resp_in       = '0;
        resp_in.valid = gnt_int;
        if (gnt_int) begin
            if (hit) begin
                if (!we) begin
                    resp_in.rdata = mem_q[word_idx];
                end
            end else begin
                resp_in.err = 1'b1;
            end
        end
    end

    resp_delay_line #(
        .Latency (Latency)
    ) u_resp_delay_line (
        .clk (clk),
        .rst (rst),
        .in  (resp_in),
        .out (resp_out)
    );

    assign rvalid     = resp_out.valid;
    assign rdata      = resp_out.rdata;
    assign err        = resp_out.err;
    assign rdata_intg = INTG_ZERO;

    logic unused_wdata_intg;
    assign unused_wdata_intg = ^wdata_intg;

endmodule

// File: tb/tb_data_bus_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_data_bus_mem_responder
//   Two responders share one stimulus stream: dut0 with default parameters
//   (Latency=1, immediate grant) and dut1 with Latency=3 and delayed grant.
//   A transaction-level model per instance (word array + queue of responses
//   tagged with the cycle they are due) predicts gnt, rvalid, rdata and err
//   every cycle. Directed steps cover the listed scenarios, followed by a
//   randomized phase.
// ----------------------------------------------------------------------------
module tb_data_bus_mem_responder;

    localparam logic [31:0] BASE  = 32'h0001_0000;
    localparam int          WORDS = 1024;
    localparam int          LAT0  = 1;
    localparam int          LAT1  = 3;

    typedef struct {
        int          due;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [6:0]  wdata_intg;

    logic        gnt0, rvalid0, err0;
    logic [31:0] rdata0;
    logic [6:0]  rdata_intg0;
    logic        gnt1, rvalid1, err1;
    logic [31:0] rdata1;
    logic [6:0]  rdata_intg1;

    always #5 clk = ~clk;

    data_bus_mem_responder dut0 (
        .clk (clk), .rst (rst), .req (req), .gnt (gnt0), .we (we), .be (be),
        .addr (addr), .wdata (wdata), .wdata_intg (wdata_intg),
        .rvalid (rvalid0), .rdata (rdata0), .rdata_intg (rdata_intg0), .err (err0)
    );

    data_bus_mem_responder #(
        .Latency  (LAT1),
        .GntDelay (1)
    ) dut1 (
        .clk (clk), .rst (rst), .req (req), .gnt (gnt1), .we (we), .be (be),
        .addr (addr), .wdata (wdata), .wdata_intg (wdata_intg),
        .rvalid (rvalid1), .rdata (rdata1), .rdata_intg (rdata_intg1), .err (err1)
    );

    // Reference state
    logic [31:0] mem0 [WORDS];
    logic [31:0] mem1 [WORDS];
    exp_t        q0 [$];
    exp_t        q1 [$];
    logic        waiting1;   // dut1 has seen req and will grant next cycle
    int          cyc;

    // Last sampled values, for directed spot checks
    logic        s0_rvalid, s0_err, s1_gnt;
    logic [31:0] s0_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] b);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // One bus cycle: drive at negedge, check everything, advance the model.
    task automatic step(input logic r, input logic w, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] d, input logic rs);
        logic        g0, g1, hit, ev;
        logic [31:0] off, er, rd;
        logic        ee;
        int          idx;
        exp_t        e;

        @(negedge clk);
        rst = rs; req = r; we = w; be = b; addr = a; wdata = d;
        wdata_intg = 7'($urandom);
        #1;

        if (rs) begin
            q0.delete();
            q1.delete();
            waiting1 = 1'b0;
        end
        g0 = r && !rs;
        g1 = r && waiting1 && !rs;

        // dut0
        ev = 1'b0; er = '0; ee = 1'b0;
        if (q0.size() > 0 && q0[0].due == cyc) begin
            e = q0.pop_front();
            ev = 1'b1; er = e.rdata; ee = e.err;
        end
        chk("gnt0", 32'(gnt0), 32'(g0));
        chk("rvalid0", 32'(rvalid0), 32'(ev));
        chk("rdata0", rdata0, er);
        chk("err0", 32'(err0), 32'(ee));
        chk("rdata_intg0", 32'(rdata_intg0), 32'd0);

        // dut1
        ev = 1'b0; er = '0; ee = 1'b0;
        if (q1.size() > 0 && q1[0].due == cyc) begin
            e = q1.pop_front();
            ev = 1'b1; er = e.rdata; ee = e.err;
        end
        chk("gnt1", 32'(gnt1), 32'(g1));
        chk("rvalid1", 32'(rvalid1), 32'(ev));
        chk("rdata1", rdata1, er);
        chk("err1", 32'(err1), 32'(ee));

        s0_rvalid = rvalid0; s0_rdata = rdata0; s0_err = err0; s1_gnt = gnt1;

        // Model the grant edge
        off = a - BASE;
        hit = off < 32'(4 * WORDS);
        idx = int'(off[11:2]);
        if (g0) begin
            rd = (hit && !w) ? mem0[idx] : 32'd0;
            q0.push_back('{due: cyc + LAT0, rdata: rd, err: !hit});
            if (hit && w) mem0[idx] = merge(mem0[idx], d, b);
        end
        if (g1) begin
            rd = (hit && !w) ? mem1[idx] : 32'd0;
            q1.push_back('{due: cyc + LAT1, rdata: rd, err: !hit});
            if (hit && w) mem1[idx] = merge(mem1[idx], d, b);
        end
        waiting1 = rs ? 1'b0 : (!waiting1 && r);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    endtask

    // Request held two cycles so both grant styles accept it once or more.
    task automatic txn(input logic w, input logic [3:0] b, input logic [31:0] a,
                       input logic [31:0] d);
        step(1'b1, w, b, a, d, 1'b0);
        step(1'b1, w, b, a, d, 1'b0);
        step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        logic [31:0] w1023, x;
        logic [5:0]  gpat;
        logic        r, w, rs;
        logic [3:0]  b;
        logic [31:0] a;
        int          sel;

        rst = 1'b1; req = 1'b0; we = 1'b0; be = '0; addr = '0; wdata = '0;
        wdata_intg = '0; waiting1 = 1'b0; cyc = 0;

        // Reset: all outputs zero
        step(1'b1, 1'b1, 4'hF, BASE, 32'h1234_5678, 1'b1);
        step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        idle(2);

        // Preload the words used below (contents are not reset)
        for (int i = 0; i < 16; i++) txn(1'b1, 4'hF, BASE + 32'(4 * i), $urandom);
        w1023 = $urandom;
        txn(1'b1, 4'hF, BASE + 32'h0FFC, w1023);

        // Basic write / read
        txn(1'b1, 4'hF, 32'h0001_0010, 32'hDEAD_BEEF);
        step(1'b1, 1'b0, 4'h0, 32'h0001_0010, 32'h0, 1'b0);
        step(1'b1, 1'b0, 4'h0, 32'h0001_0010, 32'h0, 1'b0);
        chk("basic_rvalid", 32'(s0_rvalid), 32'd1);
        chk("basic_rdata", s0_rdata, 32'hDEAD_BEEF);
        chk("basic_err", 32'(s0_err), 32'd0);
        idle(4);

        // Byte enables
        txn(1'b1, 4'hF, 32'h0001_0020, 32'h1122_3344);
        txn(1'b1, 4'b0101, 32'h0001_0020, 32'hAABB_CCDD);
        step(1'b1, 1'b0, 4'h0, 32'h0001_0020, 32'h0, 1'b0);
        step(1'b1, 1'b0, 4'h0, 32'h0001_0020, 32'h0, 1'b0);
        chk("be_rdata", s0_rdata, 32'h11BB_33DD);
        idle(4);

        // Misses: above the window and wrapped below it
        step(1'b1, 1'b0, 4'h0, 32'h0001_1000, 32'h0, 1'b0);
        step(1'b1, 1'b0, 4'h0, 32'h0001_1000, 32'h0, 1'b0);
        chk("miss_rd_err", 32'(s0_err), 32'd1);
        chk("miss_rd_rdata", s0_rdata, 32'd0);
        step(1'b1, 1'b1, 4'hF, 32'h0000_FFFC, 32'hFFFF_FFFF, 1'b0);
        step(1'b1, 1'b1, 4'hF, 32'h0000_FFFC, 32'hFFFF_FFFF, 1'b0);
        chk("miss_wr_err", 32'(s0_err), 32'd1);
        idle(4);
        step(1'b1, 1'b0, 4'h0, BASE + 32'h0FFC, 32'h0, 1'b0);
        step(1'b1, 1'b0, 4'h0, BASE + 32'h0FFC, 32'h0, 1'b0);
        chk("miss_word1023", s0_rdata, w1023);
        idle(4);

        // Back-to-back write then read of the same word
        x = $urandom;
        step(1'b1, 1'b1, 4'hF, BASE + 32'h14, x, 1'b0);
        step(1'b1, 1'b0, 4'h0, BASE + 32'h14, 32'h0, 1'b0);
        step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        chk("raw_rdata", s0_rdata, x);
        idle(4);

        // Four consecutive reads of words 0..3
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 4'h0, BASE + 32'(4 * i), 32'h0, 1'b0);
        idle(5);

        // Delayed grant: req held six cycles, then a dropped request
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 4'h0, BASE + 32'h8, 32'h0, 1'b0);
            gpat[i] = s1_gnt;
        end
        chk("gnt_pattern", 32'(gpat), 32'b10_1010);
        idle(5);
        step(1'b1, 1'b0, 4'h0, BASE + 32'hC, 32'h0, 1'b0);
        idle(5);

        // Reset with reads in flight
        step(1'b1, 1'b0, 4'h0, BASE + 32'h4, 32'h0, 1'b0);
        step(1'b1, 1'b0, 4'h0, BASE + 32'h4, 32'h0, 1'b0);
        step(1'b1, 1'b1, 4'hF, BASE + 32'h4, 32'hFFFF_0000, 1'b1);
        chk("rst_rvalid", 32'(s0_rvalid), 32'd0);
        step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        idle(5);
        txn(1'b0, 4'h0, BASE + 32'h4, 32'h0);
        idle(4);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            r   = $urandom_range(0, 3) != 0;
            w   = 1'($urandom_range(0, 1));
            b   = 4'($urandom);
            sel = $urandom_range(0, 9);
            if (sel < 7)       a = BASE + 32'(4 * $urandom_range(0, 15));
            else if (sel == 7) a = BASE + 32'h0FFC;
            else if (sel == 8) a = 32'h0001_1000 + 32'(4 * $urandom_range(0, 255));
            else               a = 32'h0000_FFFC - 32'(4 * $urandom_range(0, 15));
            a  = a + 32'($urandom_range(0, 3));
            rs = $urandom_range(0, 59) == 0;
            step(r, w, b, a, $urandom, rs);
        end
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
